// File: rtl/pulse_pio_pkg.sv
// Shared definitions for the pulse PIO: register addresses, STATUS bit
// positions and the one-shot state encoding.
package pulse_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_LEN    = 3'd1;
    localparam logic [2:0] ADDR_GO     = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;

    localparam int ST_BUSY = 0;
    localparam int ST_OVR  = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/pulse_oneshot.sv
// One-shot pulse engine: latches a bit mask and holds it for max(len,1)
// cycles, then drops it without software involvement.
module pulse_oneshot
    import pulse_pio_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   start_mask,
    input  logic [PULSE_W-1:0] len,
    output logic [WIDTH-1:0]   mask,
    output logic               busy
);

    pulse_state_e       state_q, state_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   mask_q, mask_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                // A zero-length request still produces a single-cycle pulse.
                if (start && (start_mask != '0)) begin
                    mask_d  = start_mask;
                    cnt_d   = (len == '0) ? PULSE_W'(1) : len;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                cnt_d = cnt_q - PULSE_W'(1);
                if (cnt_q == PULSE_W'(1)) begin
                    mask_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mask = mask_q;
    assign busy = (state_q == ACTIVE);

endmodule

// File: rtl/pulse_pio_ctrl.sv
// Avalon-MM output PIO with level register, atomic set/clear aliases and a
// hardware one-shot strobe generator with overrun flag.
module pulse_pio_ctrl
    import pulse_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PULSE_W     = 16,
    parameter int DEFAULT_LEN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    logic [WIDTH-1:0]   data_q, data_d;
    logic [PULSE_W-1:0] len_q, len_d;
    logic               ovr_q, ovr_d;

    logic               wr_en;
    logic               go_wr;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH-1:0]   pulse_mask;
    logic               pulse_busy;
    logic               unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign go_wr     = wr_en && (address == ADDR_GO);
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    pulse_oneshot #(
        .WIDTH   (WIDTH),
        .PULSE_W (PULSE_W)
    ) u_oneshot (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (go_wr & ~pulse_busy),
        .start_mask (wd),
        .len        (len_q),
        .mask       (pulse_mask),
        .busy       (pulse_busy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            len_q  <= PULSE_W'(DEFAULT_LEN);
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            ovr_q  <= ovr_d;
        end
    end

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        ovr_d  = ovr_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d = wd;
                ADDR_LEN:    len_d  = writedata[PULSE_W-1:0];
                ADDR_STATUS: if (writedata[ST_OVR]) ovr_d = 1'b0;
                ADDR_SET:    data_d = data_q | wd;
                ADDR_CLR:    data_d = data_q & ~wd;
                default:     ;
            endcase
        end
        // GO while a pulse runs (last cycle included) is dropped and flagged.
        if (go_wr && pulse_busy) ovr_d = 1'b1;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]   = data_q;
            ADDR_LEN:    readdata[PULSE_W-1:0] = len_q;
            ADDR_GO:     readdata[WIDTH-1:0]   = pulse_mask;
            ADDR_STATUS: begin
                readdata[ST_BUSY] = pulse_busy;
                readdata[ST_OVR]  = ovr_q;
            end
            default:     ;
        endcase
    end

    assign out_port = data_q | pulse_mask;
    assign busy     = pulse_busy;

endmodule

// File: tb/tb_pulse_pio_ctrl.sv
// Self-checking bench for pulse_pio_ctrl: a per-edge behavioural model checked
// every cycle, plus directed transactions with literal expectations.
module tb_pulse_pio_ctrl;

    localparam int WIDTH       = 8;
    localparam int PULSE_W     = 16;
    localparam int DEFAULT_LEN = 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             busy;

    int checks = 0;
    int errors = 0;

    pulse_pio_ctrl #(
        .WIDTH       (WIDTH),
        .PULSE_W     (PULSE_W),
        .DEFAULT_LEN (DEFAULT_LEN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a pulse is an absolute window of edge numbers [start, m_end).
    int         edge_cnt = 0;
    int         m_end = -1;
    logic [7:0]  m_data = '0;
    logic [7:0]  m_mask = '0;
    logic [15:0] m_len = 16'(DEFAULT_LEN);
    logic        m_ovr = 1'b0;

    function automatic logic m_busy();
        return (edge_cnt - 1) < m_end;
    endfunction

    function automatic logic [7:0] m_pmask();
        return m_busy() ? m_mask : 8'h00;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, m_data};
            3'd1:    return {16'h0, m_len};
            3'd2:    return {24'h0, m_pmask()};
            3'd3:    return {30'h0, m_ovr, m_busy()};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int   k;
        logic set_ovr;
        if (!reset_n) begin
            m_data = '0;
            m_mask = '0;
            m_len  = 16'(DEFAULT_LEN);
            m_ovr  = 1'b0;
            m_end  = -1;
        end else begin
            k       = edge_cnt;
            set_ovr = 1'b0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: m_len  = writedata[15:0];
                    3'd2: begin
                        if (k - 1 < m_end) set_ovr = 1'b1;
                        else if (writedata[7:0] != 8'h00) begin
                            m_mask = writedata[7:0];
                            m_end  = k + ((m_len == 16'h0) ? 1 : int'(m_len));
                        end
                    end
                    3'd3: if (writedata[1]) m_ovr = 1'b0;
                    3'd4: m_data = m_data | writedata[7:0];
                    3'd5: m_data = m_data & ~writedata[7:0];
                    default: ;
                endcase
            end
            if (set_ovr) m_ovr = 1'b1;
            edge_cnt++;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cyc_out_port", {24'h0, out_port}, {24'h0, m_data | m_pmask()});
            chk("cyc_busy", {31'h0, busy}, {31'h0, m_busy()});
            chk("cyc_readdata", readdata, m_read(address));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("write addr=%0d data=0x%0h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        $display("read  addr=%0d data=0x%0h", a, readdata);
        chk(nm, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state of the whole map.
        rd(3'd0, 32'h0, "rst_data");
        rd(3'd1, 32'(DEFAULT_LEN), "rst_len");
        rd(3'd2, 32'h0, "rst_go");
        rd(3'd3, 32'h0, "rst_status");
        for (int a = 4; a < 8; a++) rd(3'(a), 32'h0, "rst_other");
        chk("rst_out_port", {24'h0, out_port}, 32'h0);

        // Level register with set/clear aliases.
        wr(3'd0, 32'hA5);  chk("data_a5", {24'h0, out_port}, 32'hA5);
        wr(3'd4, 32'h0F);  chk("outset", {24'h0, out_port}, 32'hAF);
        wr(3'd5, 32'h81);  chk("outclr", {24'h0, out_port}, 32'h2E);
        rd(3'd0, 32'h2E, "read_data");
        rd(3'd4, 32'h0, "read_outset_zero");

        // Three-cycle pulse on bit0; address stays at GO so readdata shows the mask.
        wr(3'd1, 32'd3);
        wr(3'd2, 32'h01);
        for (int i = 0; i < 3; i++) begin
            chk("len3_out", {24'h0, out_port}, 32'h2F);
            chk("len3_busy", {31'h0, busy}, 32'h1);
            chk("len3_go_rd", readdata, 32'h01);
            @(posedge clk); #1;
        end
        chk("len3_end_out", {24'h0, out_port}, 32'h2E);
        chk("len3_end_busy", {31'h0, busy}, 32'h0);

        // Zero length still gives a single-cycle pulse.
        wr(3'd0, 32'h0);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'h02);
        chk("len0_out", {24'h0, out_port}, 32'h02);
        @(posedge clk); #1;
        chk("len0_end_out", {24'h0, out_port}, 32'h00);
        chk("len0_end_busy", {31'h0, busy}, 32'h0);

        // Maximum length: exactly 65535 cycles, no wrap.
        wr(3'd1, 32'hFFFF);
        wr(3'd2, 32'h01);
        repeat (65534) @(posedge clk);
        #1 chk("lenmax_last", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        chk("lenmax_end", {31'h0, busy}, 32'h0);

        // Overrun: second GO during a pulse is dropped and flagged.
        wr(3'd1, 32'd10);
        wr(3'd2, 32'h01);
        wr(3'd2, 32'h04);
        chk("ovr_out", {24'h0, out_port}, 32'h01);
        rd(3'd3, 32'h3, "ovr_status_busy");
        wait_idle(20);
        rd(3'd3, 32'h2, "ovr_status_idle");
        wr(3'd3, 32'h2);
        rd(3'd3, 32'h0, "ovr_w1c");

        // Zero-mask GO in idle does nothing.
        wr(3'd2, 32'h100);
        rd(3'd3, 32'h0, "zero_mask_go");

        // Level bit survives the pulse end.
        wr(3'd1, 32'd5);
        wr(3'd2, 32'h01);
        wr(3'd0, 32'h01);
        wait_idle(20);
        chk("level_after_pulse", {24'h0, out_port}, 32'h01);

        // Asynchronous reset aborts a running pulse.
        wr(3'd2, 32'h03);
        @(posedge clk); #1;
        chk("pre_reset_out", {24'h0, out_port}, 32'h03);
        reset_n = 1'b0;
        #1;
        chk("reset_out", {24'h0, out_port}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        rd(3'd1, 32'(DEFAULT_LEN), "post_reset_len");
        rd(3'd0, 32'h0, "post_reset_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_pio_ctrl.md
Name: pulse_pio_ctrl

Overview:
Parametrised Avalon-MM output PIO for the HPS-to-FPGA lightweight bridge. It provides a WIDTH-bit level register with atomic set and clear aliases. It also has a hardware one-shot pulse generator that drives selected bits high for a programmable number of clk cycles, then clears them on its own. It replaces single-bit start-strobe PIOs, so software no longer has to write 1 and then 0 to make a strobe.

Parameters:
WIDTH, 8, number of output bits (1..32)
PULSE_W, 16, width of the pulse-length register and down-counter (1..32)
DEFAULT_LEN, 1, reset value of PULSE_LEN (must fit in PULSE_W bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero wait states, zero read latency
out_port  out  WIDTH  data_reg OR pulse_mask
busy  out  1  high while a pulse is active

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- Reset values: data_reg=0, pulse_mask=0, len_reg=DEFAULT_LEN, cnt=0, overrun=0, state=IDLE. Therefore out_port=0, busy=0, readdata=0 when chipselect is irrelevant.
- Write = chipselect & ~write_n. Writes to unused bits are ignored. Unused read bits return 0.
- Register map:
  - 0 DATA (RW): data_reg <= writedata[WIDTH-1:0].
  - 1 PULSE_LEN (RW): len_reg <= writedata[PULSE_W-1:0].
  - 2 PULSE_GO (W): starts a pulse. Read returns pulse_mask.
  - 3 STATUS (RO/W1C): bit0=busy, bit1=overrun. Writing 1 to bit1 clears overrun.
  - 4 OUTSET (W): data_reg <= data_reg | wd. Reads 0.
  - 5 OUTCLR (W): data_reg <= data_reg & ~wd. Reads 0.
  - 6,7: reserved. Writes are ignored; reads return 0.
- All register updates take effect on the clk edge of the write. out_port reflects them in the following cycle.
- Pulse FSM, states IDLE and ACTIVE:
  - IDLE + GO write with writedata[WIDTH-1:0]!=0: pulse_mask <= masked data; cnt <= (len_reg==0 ? 1 : len_reg); go to ACTIVE.
  - IDLE + GO write with zero mask: no-op; overrun is not touched.
  - ACTIVE, each cycle: if cnt==1 then pulse_mask <= 0 and go to IDLE; else cnt <= cnt-1.
  - Result: pulse bits are high for exactly max(len_reg,1) cycles, starting the cycle after the GO write.
  - ACTIVE + GO write, including the final cycle: the write is ignored and overrun <= 1. If a W1C of overrun and a new overrun event occur in the same cycle, set wins (only possible via separate writes, so not reachable in practice).
- busy = (state==ACTIVE).
- Writing PULSE_LEN while ACTIVE changes only the next pulse; the running cnt is unaffected.
- DATA, OUTSET and OUTCLR writes during a pulse are legal. Each out_port bit is the OR of its data_reg bit and its pulse_mask bit, so a bit whose data_reg bit is set stays high after the pulse ends.
- len_reg = 2^PULSE_W-1 gives the maximum pulse length. The counter never wraps.
- A reset asserted mid-pulse aborts the pulse immediately (asynchronously): out_port goes to 0 and state to IDLE.

Decomposition:
- Shared package pulse_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_LEN=1, ADDR_GO=2, ADDR_STATUS=3, ADDR_SET=4, ADDR_CLR=5;
  - STATUS bit indices ST_BUSY=0, ST_OVR=1;
  - the state enum {IDLE, ACTIVE}.
- One sub-module is natural: pulse_oneshot (WIDTH, PULSE_W). It holds the FSM, counter and mask, with inputs start, start_mask and len, and outputs mask and busy.
- The top level contains the register file, the read mux and the overrun logic.

Test Plan:
- Reset, then read all addresses 0..7: readdata = 0,DEFAULT_LEN,0,0,0,0,0,0; out_port=0.
- Write DATA=0xA5; write OUTSET=0x0F; write OUTCLR=0x81 -> out_port 0xA5, then 0xAF, then 0x2E; reading DATA returns 0x2E.
- Write LEN=3, then GO=0x01 at cycle t -> out_port[0]=1 for cycles t+1..t+3 and 0 at t+4; busy has the same timing; PULSE_GO reads 0x01 during the pulse.
- LEN=0 then GO=0x02 -> a 1-cycle pulse on bit1. LEN=0xFFFF (PULSE_W=16) -> pulse lasts 65535 cycles with no wrap.
- LEN=10, GO=0x01, then GO=0x04 two cycles later -> bit2 never pulses; STATUS reads 0x3 while busy. After the pulse, STATUS reads 0x2; write STATUS=0x2 -> STATUS reads 0x0.
- DATA=0x01 with an active pulse on bit0 -> bit0 stays 1 after the pulse ends. Assert reset_n=0 mid-pulse -> out_port=0 and busy=0 immediately; after release, LEN reads DEFAULT_LEN.
